// File: rtl/pipeline_hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit.
// Contents: FSM state enum, redirect-source enum, stage index constants,
// and a helper that builds the per-stage nullify mask for a redirect source.
package pipeline_hazard_pkg;

    localparam int unsigned PC_W      = 32;
    localparam int unsigned MAX_STAGE = 32;

    localparam int unsigned STAGE_DECODE     = 0;
    localparam int unsigned STAGE_EXECUTE    = 1;
    localparam int unsigned STAGE_MEMORY     = 2;
    localparam int unsigned STAGE_WRITE_BACK = 3;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        JUMP   = 2'd1,
        BRANCH = 2'd2,
        EXC    = 2'd3
    } redirect_e;

    // Stages younger than the redirecting stage are squashed, plus that stage itself.
    function automatic logic [MAX_STAGE-1:0] nullify_mask(input redirect_e src,
                                                          input int unsigned exc_stage);
        logic [MAX_STAGE-1:0] m;
        m = '0;
        case (src)
            JUMP:   m = MAX_STAGE'(1);
            BRANCH: m = MAX_STAGE'(3);
            EXC: begin
                for (int unsigned i = 0; i < MAX_STAGE; i++) begin
                    if (i <= exc_stage) m[i] = 1'b1;
                end
            end
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pipeline_hazard_if.sv
// Bundle between the pipeline stages / fetch unit and the hazard unit.
// master: pipeline side (drives redirect sources, hazard operands, fetch_ready).
// slave : hazard unit (drives PC load handshake, per-stage controls, stall count).
interface pipeline_hazard_if
    import pipeline_hazard_pkg::*;
#(
    parameter int unsigned N_STAGE = 4,
    parameter int unsigned REG_W   = 5,
    parameter int unsigned CNT_W   = 32
) ();
    logic               jump_valid;
    logic [PC_W-1:0]    jump_target;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_target;
    logic               exc_valid;
    logic [PC_W-1:0]    exc_vector;
    logic               ex_mem_read;
    logic [REG_W-1:0]   ex_dest;
    logic [REG_W-1:0]   id_rs;
    logic [REG_W-1:0]   id_rt;
    logic               id_uses_rs;
    logic               id_uses_rt;
    logic               execute_busy;
    logic               fetch_ready;

    logic               load;
    logic [PC_W-1:0]    pc;
    logic               stall_fetch;
    logic [N_STAGE-1:0] stall;
    logic [N_STAGE-1:0] nullify;
    logic [N_STAGE-1:0] bubble;
    logic               busy_abort;
    logic [CNT_W-1:0]   stall_count;

    modport master (
        output jump_valid, jump_target, branch_taken, branch_target,
               exc_valid, exc_vector, ex_mem_read, ex_dest, id_rs, id_rt,
               id_uses_rs, id_uses_rt, execute_busy, fetch_ready,
        input  load, pc, stall_fetch, stall, nullify, bubble, busy_abort, stall_count
    );

    modport slave (
        input  jump_valid, jump_target, branch_taken, branch_target,
               exc_valid, exc_vector, ex_mem_read, ex_dest, id_rs, id_rt,
               id_uses_rs, id_uses_rt, execute_busy, fetch_ready,
        output load, pc, stall_fetch, stall, nullify, bubble, busy_abort, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_unit_interlock.sv
// Load-use interlock: detects a decode source reading the destination of a load
// in execute and holds decode for LOAD_LAT cycles.
// Ports: clk, rst_n; ex_mem_read_i/ex_dest_i (load in execute); id_rs_i/id_rt_i and
// id_uses_rs_i/id_uses_rt_i (decode sources); clear_i (redirect this cycle, drops the
// interlock); hold_o (combinational: stall decode / bubble execute this cycle).
module load_use_interlock
    import pipeline_hazard_pkg::*;
#(
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned REG_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_mem_read_i,
    input  logic [REG_W-1:0] ex_dest_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rs_i,
    input  logic             id_uses_rt_i,
    input  logic             clear_i,
    output logic             hold_o
);
    localparam int unsigned LAT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic             hazard_c;

    // r0 is hardwired zero, so a load to it never creates a dependency.
    assign hazard_c = ex_mem_read_i && (ex_dest_i != '0) &&
                      ((id_uses_rs_i && (id_rs_i == ex_dest_i)) ||
                       (id_uses_rt_i && (id_rt_i == ex_dest_i)));

    // The hazard cycle itself is the first stall cycle; the counter covers the rest.
    always_comb begin
        cnt_d  = cnt_q;
        hold_o = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            hold_o = 1'b1;
            cnt_d  = cnt_q - LAT_W'(1);
        end else if (hazard_c) begin
            hold_o = 1'b1;
            cnt_d  = LAT_W'(LOAD_LAT - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/pipeline_hazard_unit.sv
// Pipeline hazard unit: arbitrates exception/branch/jump redirects and holds them
// until fetch accepts, applies the load-use interlock and execute-busy stalls, and
// counts fetch-stall cycles.
// Ports: clk, rst_n (async, active low); hz_if (slave side of pipeline_hazard_if).
// Redirect, mask, stall and bubble outputs are combinational; stall_count is registered.
module pipeline_hazard_unit
    import pipeline_hazard_pkg::*;
#(
    parameter int unsigned N_STAGE   = 4,
    parameter int unsigned EXC_STAGE = 2,
    parameter int unsigned LOAD_LAT  = 1,
    parameter int unsigned REG_W     = 5,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    pipeline_hazard_if.slave hz_if
);
    state_e               state_q, state_d;
    logic [PC_W-1:0]      held_pc_q, held_pc_d;
    logic [CNT_W-1:0]     stall_count_q, stall_count_d;
    redirect_e            src_c;
    logic                 load_c, hold_c, busy_stall_c, stall_fetch_c;
    logic [PC_W-1:0]      pc_c;
    logic [MAX_STAGE-1:0] mask_c;
    logic [N_STAGE-1:0]   nullify_c, stall_c, bubble_c;

    // Exceptions are accepted in either state; jumps and branches only while running.
    always_comb begin
        src_c = NONE;
        if (hz_if.exc_valid)                                src_c = EXC;
        else if ((state_q == RUN) && hz_if.branch_taken)    src_c = BRANCH;
        else if ((state_q == RUN) && hz_if.jump_valid)      src_c = JUMP;
    end

    // Redirect FSM: next state, held target and redirect outputs.
    always_comb begin
        state_d   = state_q;
        held_pc_d = held_pc_q;
        load_c    = 1'b0;
        pc_c      = '0;
        mask_c    = '0;
        case (state_q)
            RUN: begin
                if (src_c != NONE) begin
                    load_c = 1'b1;
                    mask_c = nullify_mask(src_c, EXC_STAGE);
                    case (src_c)
                        EXC:     pc_c = hz_if.exc_vector;
                        BRANCH:  pc_c = hz_if.branch_target;
                        default: pc_c = hz_if.jump_target;
                    endcase
                    if (!hz_if.fetch_ready) begin
                        state_d   = WAIT;
                        held_pc_d = pc_c;
                    end
                end
            end
            WAIT: begin
                load_c = 1'b1;
                if (src_c == EXC) begin
                    pc_c      = hz_if.exc_vector;
                    mask_c    = nullify_mask(EXC, EXC_STAGE);
                    held_pc_d = hz_if.exc_vector;
                end else begin
                    pc_c   = held_pc_q;
                    mask_c = MAX_STAGE'(1);
                end
                if (hz_if.fetch_ready) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    load_use_interlock #(
        .LOAD_LAT (LOAD_LAT),
        .REG_W    (REG_W)
    ) u_interlock (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_mem_read_i (hz_if.ex_mem_read),
        .ex_dest_i     (hz_if.ex_dest),
        .id_rs_i       (hz_if.id_rs),
        .id_rt_i       (hz_if.id_rt),
        .id_uses_rs_i  (hz_if.id_uses_rs),
        .id_uses_rt_i  (hz_if.id_uses_rt),
        .clear_i       (load_c),
        .hold_o        (hold_c)
    );

    // An exception aborts the busy unit instead of waiting behind it.
    assign busy_stall_c  = hz_if.execute_busy && !hz_if.exc_valid;
    assign stall_fetch_c = !load_c && (busy_stall_c || hold_c);
    assign nullify_c     = mask_c[N_STAGE-1:0];

    // Per-stage stall/bubble; a nullified stage is never also stalled.
    always_comb begin
        stall_c                 = '0;
        bubble_c                = '0;
        stall_c[STAGE_DECODE]   = busy_stall_c || hold_c;
        stall_c[STAGE_EXECUTE]  = busy_stall_c;
        stall_c                 = stall_c & ~nullify_c;
        bubble_c[STAGE_EXECUTE] = hold_c && !hz_if.execute_busy;
        bubble_c[STAGE_MEMORY]  = busy_stall_c;
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_fetch_c && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            held_pc_q     <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            held_pc_q     <= held_pc_d;
            stall_count_q <= stall_count_d;
        end
    end

    // All controls are forced idle while reset is asserted.
    assign hz_if.load        = rst_n && load_c;
    assign hz_if.pc          = rst_n ? pc_c : '0;
    assign hz_if.stall_fetch = rst_n && stall_fetch_c;
    assign hz_if.nullify     = rst_n ? nullify_c : '0;
    assign hz_if.stall       = rst_n ? stall_c : '0;
    assign hz_if.bubble      = rst_n ? bubble_c : '0;
    assign hz_if.busy_abort  = rst_n && hz_if.execute_busy && hz_if.exc_valid;
    assign hz_if.stall_count = stall_count_q;
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Self-checking bench for pipeline_hazard_unit: directed vectors, a behavioural
// model compared every cycle, and hand-computed literal expectations.
module tb_pipeline_hazard_unit;
    localparam int unsigned N_STAGE   = 4;
    localparam int unsigned EXC_STAGE = 2;
    localparam int unsigned LOAD_LAT  = 2;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned CNT_W     = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_if #(.N_STAGE(N_STAGE), .REG_W(REG_W), .CNT_W(CNT_W)) hz ();

    pipeline_hazard_unit #(
        .N_STAGE(N_STAGE), .EXC_STAGE(EXC_STAGE), .LOAD_LAT(LOAD_LAT),
        .REG_W(REG_W), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz_if (hz)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model state
    bit              m_wait = 0;
    logic [31:0]     m_held = '0;
    int              m_ilk  = 0;
    longint unsigned m_scnt = 0;

    always @(negedge clk) begin : cmp
        bit          e_load, e_sf, e_abort, hazard, hold, busy;
        logic [31:0] e_pc;
        int          e_null, e_stall, e_bub, exc_m;
        exc_m = (1 << (EXC_STAGE + 1)) - 1;
        if (!rst_n) begin
            chk("rst_load", 64'(hz.load), 64'd0);
            chk("rst_pc", 64'(hz.pc), 64'd0);
            chk("rst_sf", 64'(hz.stall_fetch), 64'd0);
            chk("rst_vec", 64'({hz.stall, hz.nullify, hz.bubble, hz.busy_abort}), 64'd0);
            chk("rst_cnt", 64'(hz.stall_count), 64'd0);
            m_wait = 0; m_held = '0; m_ilk = 0; m_scnt = 0;
        end else begin
            e_load = 1; e_pc = '0; e_null = 0;
            if (m_wait) begin
                e_pc   = hz.exc_valid ? hz.exc_vector : m_held;
                e_null = hz.exc_valid ? exc_m : 1;
            end else if (hz.exc_valid) begin
                e_pc = hz.exc_vector;    e_null = exc_m;
            end else if (hz.branch_taken) begin
                e_pc = hz.branch_target; e_null = 3;
            end else if (hz.jump_valid) begin
                e_pc = hz.jump_target;   e_null = 1;
            end else begin
                e_load = 0;
            end
            hazard = hz.ex_mem_read && (hz.ex_dest != 0) &&
                     ((hz.id_uses_rs && hz.id_rs == hz.ex_dest) ||
                      (hz.id_uses_rt && hz.id_rt == hz.ex_dest));
            hold    = !e_load && (m_ilk > 0 || hazard);
            busy    = hz.execute_busy && !hz.exc_valid;
            e_abort = hz.execute_busy && hz.exc_valid;
            e_sf    = !e_load && (busy || hold);
            e_stall = (((busy || hold) ? 1 : 0) | (busy ? 2 : 0)) & ~e_null;
            e_bub   = ((hold && !hz.execute_busy) ? 2 : 0) | (busy ? 4 : 0);

            chk("load", 64'(hz.load), 64'(e_load));
            chk("pc", 64'(hz.pc), 64'(e_pc));
            chk("nullify", 64'(hz.nullify), 64'(e_null));
            chk("stall", 64'(hz.stall), 64'(e_stall));
            chk("bubble", 64'(hz.bubble), 64'(e_bub));
            chk("stall_fetch", 64'(hz.stall_fetch), 64'(e_sf));
            chk("busy_abort", 64'(hz.busy_abort), 64'(e_abort));
            chk("stall_count", 64'(hz.stall_count), m_scnt);

            if (e_load)      m_ilk = 0;
            else if (m_ilk > 0) m_ilk = m_ilk - 1;
            else if (hazard) m_ilk = LOAD_LAT - 1;
            if (e_load) begin
                m_wait = !hz.fetch_ready;
                if (!hz.fetch_ready) m_held = e_pc;
            end
            if (e_sf && m_scnt < 64'hFFFF_FFFF) m_scnt++;
        end
    end

    task automatic idle();
        hz.jump_valid = 0;   hz.jump_target = '0;
        hz.branch_taken = 0; hz.branch_target = '0;
        hz.exc_valid = 0;    hz.exc_vector = '0;
        hz.ex_mem_read = 0;  hz.ex_dest = '0;
        hz.id_rs = '0;       hz.id_rt = '0;
        hz.id_uses_rs = 0;   hz.id_uses_rt = 0;
        hz.execute_busy = 0; hz.fetch_ready = 1;
    endtask

    task automatic next_cycle(); @(posedge clk); #1; endtask
    task automatic settle();     @(negedge clk); #1; endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        idle();
        rst_n = 0;
        settle();
        chk("lit_rst_load", 64'(hz.load), 64'd0);
        chk("lit_rst_cnt", 64'(hz.stall_count), 64'd0);
        next_cycle(); rst_n = 1;

        // jump accepted immediately
        next_cycle(); idle(); hz.jump_valid = 1; hz.jump_target = 32'h0040_0100;
        settle();
        chk("lit_jump_load", 64'(hz.load), 64'd1);
        chk("lit_jump_pc", 64'(hz.pc), 64'h0040_0100);
        chk("lit_jump_null", 64'(hz.nullify), 64'b0001);
        next_cycle(); idle(); settle();
        chk("lit_jump_done", 64'(hz.load), 64'd0);

        // branch held for three not-ready cycles
        next_cycle(); idle(); hz.branch_taken = 1; hz.branch_target = 32'h80; hz.fetch_ready = 0;
        settle();
        chk("lit_br_pc", 64'(hz.pc), 64'h80);
        chk("lit_br_null", 64'(hz.nullify), 64'b0011);
        for (int i = 0; i < 2; i++) begin
            next_cycle(); idle(); hz.fetch_ready = 0; settle();
            chk("lit_wait_load", 64'(hz.load), 64'd1);
            chk("lit_wait_pc", 64'(hz.pc), 64'h80);
            chk("lit_wait_null0", 64'(hz.nullify[0]), 64'd1);
        end
        next_cycle(); idle(); settle();
        chk("lit_accept_pc", 64'(hz.pc), 64'h80);
        next_cycle(); idle(); settle();
        chk("lit_back_run", 64'(hz.load), 64'd0);

        // exception replaces a held branch
        next_cycle(); idle(); hz.branch_taken = 1; hz.branch_target = 32'h80; hz.fetch_ready = 0;
        next_cycle(); idle(); hz.fetch_ready = 0; hz.exc_valid = 1; hz.exc_vector = 32'h8000_0180;
        settle();
        chk("lit_exc_pc", 64'(hz.pc), 64'h8000_0180);
        chk("lit_exc_null", 64'(hz.nullify), 64'b0111);
        next_cycle(); idle(); hz.fetch_ready = 0; hz.jump_valid = 1; hz.jump_target = 32'h1234;
        settle();
        chk("lit_exc_held", 64'(hz.pc), 64'h8000_0180);
        next_cycle(); idle(); settle();
        next_cycle(); idle(); settle();

        // load-use interlock, LOAD_LAT=2
        next_cycle(); idle(); hz.ex_mem_read = 1; hz.ex_dest = 5; hz.id_rs = 5; hz.id_uses_rs = 1;
        settle();
        chk("lit_lu_sf", 64'(hz.stall_fetch), 64'd1);
        chk("lit_lu_stall", 64'(hz.stall), 64'b0001);
        chk("lit_lu_bubble", 64'(hz.bubble), 64'b0010);
        next_cycle(); idle(); settle();
        chk("lit_lu_sf2", 64'(hz.stall_fetch), 64'd1);
        next_cycle(); idle(); settle();
        chk("lit_lu_end", 64'(hz.stall_fetch), 64'd0);
        chk("lit_lu_cnt", 64'(hz.stall_count), 64'd2);
        next_cycle(); idle(); hz.ex_mem_read = 1; hz.ex_dest = 0; hz.id_uses_rs = 1; settle();
        chk("lit_r0_nohaz", 64'(hz.stall_fetch), 64'd0);
        next_cycle(); idle(); hz.ex_mem_read = 1; hz.ex_dest = 7; hz.id_rt = 7; settle();
        chk("lit_unused_rt", 64'(hz.stall_fetch), 64'd0);
        next_cycle(); idle(); hz.ex_mem_read = 1; hz.ex_dest = 7; hz.id_rt = 7; hz.id_uses_rt = 1;
        settle();
        chk("lit_rt_haz", 64'(hz.stall_fetch), 64'd1);
        next_cycle(); idle(); settle();
        next_cycle(); idle(); settle();
        chk("lit_rt_cnt", 64'(hz.stall_count), 64'd4);

        // execute busy five cycles, exception on the third
        for (int c = 1; c <= 5; c++) begin
            next_cycle(); idle(); hz.execute_busy = 1;
            if (c == 3) begin hz.exc_valid = 1; hz.exc_vector = 32'h8000_0180; end
            settle();
            if (c == 3) begin
                chk("lit_abort", 64'(hz.busy_abort), 64'd1);
                chk("lit_abort_load", 64'(hz.load), 64'd1);
                chk("lit_abort_stall", 64'(hz.stall[1:0]), 64'd0);
            end else begin
                chk("lit_busy_stall", 64'(hz.stall), 64'b0011);
                chk("lit_busy_bubble", 64'(hz.bubble), 64'b0100);
            end
        end
        next_cycle(); idle(); settle();
        chk("lit_busy_cnt", 64'(hz.stall_count), 64'd8);

        // redirect beats interlock and clears it
        next_cycle(); idle(); hz.jump_valid = 1; hz.jump_target = 32'h100;
        hz.ex_mem_read = 1; hz.ex_dest = 3; hz.id_rs = 3; hz.id_uses_rs = 1;
        settle();
        chk("lit_redir_sf", 64'(hz.stall_fetch), 64'd0);
        next_cycle(); idle(); settle();
        chk("lit_ilk_cleared", 64'(hz.stall_fetch), 64'd0);
        // nullify wins over stall on decode
        next_cycle(); idle(); hz.jump_valid = 1; hz.jump_target = 32'h200; hz.execute_busy = 1;
        settle();
        chk("lit_null_wins", 64'(hz.stall), 64'b0010);

        // reset during WAIT
        next_cycle(); idle(); hz.branch_taken = 1; hz.branch_target = 32'h80; hz.fetch_ready = 0;
        next_cycle(); idle(); hz.fetch_ready = 0; settle();
        chk("lit_pre_rst", 64'(hz.load), 64'd1);
        next_cycle(); rst_n = 0; #1;
        chk("lit_rst_now_load", 64'(hz.load), 64'd0);
        chk("lit_rst_now_pc", 64'(hz.pc), 64'd0);
        settle();
        next_cycle(); rst_n = 1; hz.fetch_ready = 1;
        settle();
        chk("lit_post_rst_load", 64'(hz.load), 64'd0);
        chk("lit_post_rst_cnt", 64'(hz.stall_count), 64'd0);
        next_cycle(); settle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
